// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: ALU operator codes, opcodes, operand selects
// and the decoded-field record carried by the decode pipeline register.
package rv32i_pkg;

    localparam logic [5:0] ALU_ADD = 6'b011000;
    localparam logic [5:0] ALU_SUB = 6'b011001;
    localparam logic [5:0] ALU_XOR = 6'b101111;
    localparam logic [5:0] ALU_OR  = 6'b101110;
    localparam logic [5:0] ALU_AND = 6'b010101;
    localparam logic [5:0] ALU_SRA = 6'b100100;
    localparam logic [5:0] ALU_SRL = 6'b100101;
    localparam logic [5:0] ALU_SLL = 6'b100111;
    localparam logic [5:0] ALU_LTS = 6'b000000;
    localparam logic [5:0] ALU_LTU = 6'b000001;
    localparam logic [5:0] ALU_GES = 6'b001010;
    localparam logic [5:0] ALU_GEU = 6'b001011;
    localparam logic [5:0] ALU_EQ  = 6'b001100;
    localparam logic [5:0] ALU_NE  = 6'b001101;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    typedef struct packed {
        logic [5:0]  alu_op;
        logic [1:0]  src_a;
        logic [1:0]  src_b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_we;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        illegal;
    } dec_t;

    // alt selects SUB/SRA over ADD/SRL (funct7 bit 5)
    function automatic logic [5:0] alu_op_f3(input logic [2:0] f3, input logic alt);
        logic [5:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_LTS;
            3'b011:  op = ALU_LTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_decode_stage_if.sv
// Instruction-in / decoded-fields-out bundle of the decode stage.
interface rv32i_decode_stage_if #(parameter int ILLEGAL_CNT_W = 16);
    logic [31:0]              instr_i;
    logic                     instr_valid_i;
    logic                     instr_ready_o;
    logic                     flush_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [5:0]               alu_op_o;
    logic [1:0]               src_a_sel_o;
    logic [1:0]               src_b_sel_o;
    logic [31:0]              imm_o;
    logic [4:0]               rs1_addr_o;
    logic [4:0]               rs2_addr_o;
    logic [4:0]               rd_addr_o;
    logic                     reg_we_o;
    logic                     branch_o;
    logic                     jal_o;
    logic                     jalr_o;
    logic                     mem_req_o;
    logic                     mem_we_o;
    logic [2:0]               mem_size_o;
    logic                     illegal_instr_o;
    logic [ILLEGAL_CNT_W-1:0] illegal_cnt_o;

    modport slave (
        input  instr_i, instr_valid_i, flush_i, out_ready_i,
        output instr_ready_o, out_valid_o, alu_op_o, src_a_sel_o, src_b_sel_o, imm_o,
               rs1_addr_o, rs2_addr_o, rd_addr_o, reg_we_o, branch_o, jal_o, jalr_o,
               mem_req_o, mem_we_o, mem_size_o, illegal_instr_o, illegal_cnt_o
    );

    modport master (
        output instr_i, instr_valid_i, flush_i, out_ready_i,
        input  instr_ready_o, out_valid_o, alu_op_o, src_a_sel_o, src_b_sel_o, imm_o,
               rs1_addr_o, rs2_addr_o, rd_addr_o, reg_we_o, branch_o, jal_o, jalr_o,
               mem_req_o, mem_we_o, mem_size_o, illegal_instr_o, illegal_cnt_o
    );
endinterface

// File: rtl/rv32i_decode_core.sv
// Combinational RV32I decoder: instruction word to ALU/operand/control fields.
module rv32i_decode_core
    import rv32i_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0]  opcode;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        legal;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    dec_t        d;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'b0};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        d        = '0;
        d.alu_op = ALU_ADD;
        d.src_a  = SRC_A_RS1;
        d.src_b  = SRC_B_RS2;
        d.rs1    = instr_i[19:15];
        d.rs2    = instr_i[24:20];
        d.rd     = instr_i[11:7];
        legal    = 1'b0;
        case (opcode)
            OPC_OP: begin
                d.alu_op = alu_op_f3(f3, f7[5]);
                d.reg_we = 1'b1;
                legal    = (f7 == 7'b0000000) ||
                           (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            end
            OPC_OP_IMM: begin
                d.alu_op = alu_op_f3(f3, (f3 == 3'b101) && f7[5]);
                d.src_b  = SRC_B_IMM;
                d.imm    = imm_i;
                d.reg_we = 1'b1;
                if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else                   legal = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                d.src_a  = (opcode == OPC_LUI) ? SRC_A_ZERO : SRC_A_PC;
                d.src_b  = SRC_B_IMM;
                d.imm    = imm_u;
                d.reg_we = 1'b1;
                legal    = 1'b1;
            end
            // link value pc+4 is produced by the ALU; target adder lives in execute
            OPC_JAL, OPC_JALR: begin
                d.src_a  = SRC_A_PC;
                d.src_b  = SRC_B_FOUR;
                d.imm    = (opcode == OPC_JAL) ? imm_j : imm_i;
                d.jal    = (opcode == OPC_JAL);
                d.jalr   = (opcode == OPC_JALR);
                d.reg_we = 1'b1;
                legal    = (opcode == OPC_JAL) || (f3 == 3'b000);
            end
            OPC_BRANCH: begin
                d.imm    = imm_b;
                d.branch = 1'b1;
                legal    = 1'b1;
                case (f3)
                    3'b000:  d.alu_op = ALU_EQ;
                    3'b001:  d.alu_op = ALU_NE;
                    3'b100:  d.alu_op = ALU_LTS;
                    3'b101:  d.alu_op = ALU_GES;
                    3'b110:  d.alu_op = ALU_LTU;
                    3'b111:  d.alu_op = ALU_GEU;
                    default: legal    = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                d.src_b    = SRC_B_IMM;
                d.imm      = imm_i;
                d.mem_req  = 1'b1;
                d.reg_we   = 1'b1;
                d.mem_size = f3;
                legal      = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            end
            OPC_STORE: begin
                d.src_b    = SRC_B_IMM;
                d.imm      = imm_s;
                d.mem_req  = 1'b1;
                d.mem_we   = 1'b1;
                d.mem_size = f3;
                legal      = !f3[2] && (f3 != 3'b011);
            end
            OPC_MISC_MEM: legal = 1'b1;
            OPC_SYSTEM:   legal = 1'b0;
            default:      legal = 1'b0;
        endcase

        if (!legal) begin
            d.illegal = 1'b1;
            d.reg_we  = 1'b0;
            d.mem_req = 1'b0;
            d.mem_we  = 1'b0;
            d.branch  = 1'b0;
            d.jal     = 1'b0;
            d.jalr    = 1'b0;
        end
        if (d.rd == 5'd0) d.reg_we = 1'b0;
    end

    assign dec_o = d;

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage: one pipeline register with valid/ready toward
// execute, flush from branch resolution and a saturating illegal-word counter.
module rv32i_decode_stage
    import rv32i_pkg::*;
#(
    parameter logic [1:0] RESET_PC_SRC  = 2'd0,
    parameter int         ILLEGAL_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    rv32i_decode_stage_if.slave  bus
);

    dec_t                     dec;
    dec_t                     fields_d, fields_q;
    logic                     out_valid_d, out_valid_q;
    logic [ILLEGAL_CNT_W-1:0] illegal_cnt_d, illegal_cnt_q;
    logic                     instr_ready;
    logic                     accept;

    rv32i_decode_core u_core (
        .instr_i (bus.instr_i),
        .dec_o   (dec)
    );

    assign instr_ready = !out_valid_q || bus.out_ready_i;

    always_comb begin
        accept        = bus.instr_valid_i && instr_ready && !bus.flush_i;
        fields_d      = accept ? dec : fields_q;
        illegal_cnt_d = illegal_cnt_q;
        if (accept && dec.illegal && (illegal_cnt_q != '1))
            illegal_cnt_d = illegal_cnt_q + 1'b1;
        if (bus.flush_i)          out_valid_d = 1'b0;
        else if (accept)          out_valid_d = 1'b1;
        else if (bus.out_ready_i) out_valid_d = 1'b0;
        else                      out_valid_d = out_valid_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q   <= 1'b0;
            illegal_cnt_q <= '0;
            fields_q      <= '{src_a: RESET_PC_SRC, default: '0};
        end else begin
            out_valid_q   <= out_valid_d;
            illegal_cnt_q <= illegal_cnt_d;
            fields_q      <= fields_d;
        end
    end

    assign bus.instr_ready_o   = instr_ready;
    assign bus.out_valid_o     = out_valid_q;
    assign bus.alu_op_o        = fields_q.alu_op;
    assign bus.src_a_sel_o     = fields_q.src_a;
    assign bus.src_b_sel_o     = fields_q.src_b;
    assign bus.imm_o           = fields_q.imm;
    assign bus.rs1_addr_o      = fields_q.rs1;
    assign bus.rs2_addr_o      = fields_q.rs2;
    assign bus.rd_addr_o       = fields_q.rd;
    assign bus.reg_we_o        = fields_q.reg_we;
    assign bus.branch_o        = fields_q.branch;
    assign bus.jal_o           = fields_q.jal;
    assign bus.jalr_o          = fields_q.jalr;
    assign bus.mem_req_o       = fields_q.mem_req;
    assign bus.mem_we_o        = fields_q.mem_we;
    assign bus.mem_size_o      = fields_q.mem_size;
    assign bus.illegal_instr_o = fields_q.illegal;
    assign bus.illegal_cnt_o   = illegal_cnt_q;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: vector table streamed through a scoreboard
// queue, plus stall, flush, counter-saturation and async-reset sequences.
module tb_rv32i_decode_stage;
    import rv32i_pkg::*;

    localparam int            CW    = 3;
    localparam logic [CW-1:0] CMAX  = '1;
    localparam logic [1:0]    RST_A = 2'd1;
    localparam int            NV    = 22;

    typedef struct {
        string       name;
        logic [31:0] ins;
        dec_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32i_decode_stage_if #(.ILLEGAL_CNT_W(CW)) bus ();

    rv32i_decode_stage #(.RESET_PC_SRC(RST_A), .ILLEGAL_CNT_W(CW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    vec_t          v [NV];
    vec_t          q [$];
    vec_t          cur;
    logic          m_valid;
    logic [CW-1:0] m_cnt;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic dec_t base(input logic [31:0] ins);
        dec_t e;
        e        = '0;
        e.alu_op = ALU_ADD;
        e.rs1    = ins[19:15];
        e.rs2    = ins[24:20];
        e.rd     = ins[11:7];
        return e;
    endfunction

    task automatic put(input int i, input string nm, input logic [31:0] ins);
        v[i].name = nm;
        v[i].ins  = ins;
        v[i].exp  = base(ins);
    endtask

    task automatic init_vecs();
        put(0, "add", 32'h002081B3);   v[0].exp.reg_we = 1;
        put(1, "srai", 32'h40315093);  v[1].exp.alu_op = ALU_SRA; v[1].exp.src_b = SRC_B_IMM;
        v[1].exp.imm = 32'h403;        v[1].exp.reg_we = 1;
        put(2, "lui", 32'h123452B7);   v[2].exp.src_a = SRC_A_ZERO; v[2].exp.src_b = SRC_B_IMM;
        v[2].exp.imm = 32'h12345000;   v[2].exp.reg_we = 1;
        put(3, "ones", 32'hFFFFFFFF);  v[3].exp.illegal = 1;
        put(4, "sub", 32'h407302B3);   v[4].exp.alu_op = ALU_SUB; v[4].exp.reg_we = 1;
        put(5, "bne", 32'h00209463);   v[5].exp.alu_op = ALU_NE; v[5].exp.branch = 1;
        v[5].exp.imm = 32'd8;
        put(6, "bgeu", 32'hFE20FEE3);  v[6].exp.alu_op = ALU_GEU; v[6].exp.branch = 1;
        v[6].exp.imm = 32'hFFFFFFFC;
        put(7, "jal", 32'h010000EF);   v[7].exp.src_a = SRC_A_PC; v[7].exp.src_b = SRC_B_FOUR;
        v[7].exp.imm = 32'd16;         v[7].exp.jal = 1; v[7].exp.reg_we = 1;
        put(8, "ret", 32'h00008067);   v[8].exp.src_a = SRC_A_PC; v[8].exp.src_b = SRC_B_FOUR;
        v[8].exp.jalr = 1;
        put(9, "lw", 32'hFF812283);    v[9].exp.src_b = SRC_B_IMM; v[9].exp.imm = 32'hFFFFFFF8;
        v[9].exp.mem_req = 1;          v[9].exp.reg_we = 1; v[9].exp.mem_size = 3'd2;
        put(10, "sw", 32'h00512623);   v[10].exp.src_b = SRC_B_IMM; v[10].exp.imm = 32'd12;
        v[10].exp.mem_req = 1;         v[10].exp.mem_we = 1; v[10].exp.mem_size = 3'd2;
        put(11, "fence", 32'h0FF0000F);
        put(12, "auipc", 32'hFFFFF397); v[12].exp.src_a = SRC_A_PC; v[12].exp.src_b = SRC_B_IMM;
        v[12].exp.imm = 32'hFFFFF000;  v[12].exp.reg_we = 1;
        put(13, "nop", 32'h00000013);  v[13].exp.src_b = SRC_B_IMM;
        put(14, "sltu", 32'h0062B233); v[14].exp.alu_op = ALU_LTU; v[14].exp.reg_we = 1;
        put(15, "xori", 32'hFFF0C093); v[15].exp.alu_op = ALU_XOR; v[15].exp.src_b = SRC_B_IMM;
        v[15].exp.imm = 32'hFFFFFFFF;  v[15].exp.reg_we = 1;
        put(16, "mul", 32'h022081B3);  v[16].exp.illegal = 1;
        put(17, "br010", 32'h0020A463); v[17].exp.illegal = 1;
        put(18, "ld011", 32'hFF813283); v[18].exp.illegal = 1;
        put(19, "slli7", 32'h40111093); v[19].exp.illegal = 1;
        put(20, "ecall", 32'h00000073); v[20].exp.illegal = 1;
        put(21, "c_li", 32'h00004501);  v[21].exp.illegal = 1;
    endtask

    function automatic dec_t dut_fields();
        dec_t a;
        a.alu_op   = bus.alu_op_o;
        a.src_a    = bus.src_a_sel_o;
        a.src_b    = bus.src_b_sel_o;
        a.imm      = bus.imm_o;
        a.rs1      = bus.rs1_addr_o;
        a.rs2      = bus.rs2_addr_o;
        a.rd       = bus.rd_addr_o;
        a.reg_we   = bus.reg_we_o;
        a.branch   = bus.branch_o;
        a.jal      = bus.jal_o;
        a.jalr     = bus.jalr_o;
        a.mem_req  = bus.mem_req_o;
        a.mem_we   = bus.mem_we_o;
        a.mem_size = bus.mem_size_o;
        a.illegal  = bus.illegal_instr_o;
        return a;
    endfunction

    // ALU/operand fields of an illegal word are don't-care
    task automatic chk_fields(input vec_t e);
        dec_t a;
        a = dut_fields();
        chk($sformatf("%s.illegal", e.name), a.illegal, e.exp.illegal);
        chk($sformatf("%s.ctrl", e.name),
            {a.reg_we, a.branch, a.jal, a.jalr, a.mem_req, a.mem_we},
            {e.exp.reg_we, e.exp.branch, e.exp.jal, e.exp.jalr, e.exp.mem_req, e.exp.mem_we});
        chk($sformatf("%s.regs", e.name), {a.rs1, a.rs2, a.rd}, {e.exp.rs1, e.exp.rs2, e.exp.rd});
        if (!e.exp.illegal) begin
            chk($sformatf("%s.alu_op", e.name), a.alu_op, e.exp.alu_op);
            chk($sformatf("%s.src", e.name), {a.src_a, a.src_b}, {e.exp.src_a, e.exp.src_b});
            chk($sformatf("%s.imm", e.name), a.imm, e.exp.imm);
            chk($sformatf("%s.mem_size", e.name), a.mem_size, e.exp.mem_size);
        end
    endtask

    task automatic drive(input int idx, input logic vld);
        bus.instr_i       = v[idx].ins;
        bus.instr_valid_i = vld;
        cur               = v[idx];
    endtask

    // One clock: check ready and held output against the scoreboard, update the model, step.
    task automatic tick();
        logic rdy, acc;
        #1;
        rdy = !m_valid || bus.out_ready_i;
        chk("instr_ready", bus.instr_ready_o, rdy);
        if (m_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard: expected an entry, queue empty");
            end else begin
                chk_fields(q[0]);
            end
        end
        acc = bus.instr_valid_i && rdy && !bus.flush_i;
        if (m_valid && (bus.out_ready_i || bus.flush_i) && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            q.push_back(cur);
            if (cur.exp.illegal && m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
        end
        if (bus.flush_i)          m_valid = 1'b0;
        else if (acc)             m_valid = 1'b1;
        else if (bus.out_ready_i) m_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid", bus.out_valid_o, m_valid);
        chk("illegal_cnt", bus.illegal_cnt_o, m_cnt);
    endtask

    task automatic idle();
        bus.instr_valid_i = 1'b0;
        tick();
    endtask

    initial begin
        init_vecs();
        bus.instr_i       = '0;
        bus.instr_valid_i = 1'b0;
        bus.flush_i       = 1'b0;
        bus.out_ready_i   = 1'b1;
        m_valid           = 1'b0;
        m_cnt             = '0;
        cur               = v[0];

        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", bus.out_valid_o, 1'b0);
        chk("rst.cnt", bus.illegal_cnt_o, 0);
        chk("rst.src_a", bus.src_a_sel_o, RST_A);
        chk("rst.alu_imm", {bus.alu_op_o, bus.imm_o}, 0);
        chk("rst.ctrl", {bus.reg_we_o, bus.mem_req_o, bus.illegal_instr_o}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin drive(i, 1'b1); tick(); end
        idle();

        for (int i = 0; i < 3; i++) begin drive(3, 1'b1); tick(); end
        idle();
        chk("cnt_after_3_illegal", bus.illegal_cnt_o, 3);

        // back-to-back stream; counter saturates partway through
        for (int i = 0; i < NV; i++) begin drive(i, 1'b1); tick(); end
        idle();
        chk("cnt_saturated", bus.illegal_cnt_o, CMAX);

        // 4-cycle stall with a different word presented, then streaming release
        bus.out_ready_i = 1'b0;
        drive(0, 1'b1); tick();
        drive(4, 1'b1);
        repeat (4) tick();
        bus.out_ready_i = 1'b1;
        for (int i = 4; i < 10; i++) begin drive(i, 1'b1); tick(); end
        idle();

        // async reset while stalled
        bus.out_ready_i = 1'b0;
        drive(1, 1'b1); tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.out_valid", bus.out_valid_o, 1'b0);
        chk("async_rst.cnt", bus.illegal_cnt_o, 0);
        chk("async_rst.src_a", bus.src_a_sel_o, RST_A);
        m_valid = 1'b0;
        m_cnt   = '0;
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // flush over a held word, then flush blocking an otherwise-accepted word
        drive(3, 1'b1); tick();
        drive(3, 1'b1);
        bus.flush_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        idle();
        chk("cnt_after_flush", bus.illegal_cnt_o, 1);
        drive(2, 1'b1); tick();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_decode_stage.md
Name: rv32i_decode_stage

Overview:
Registered instruction-decode stage that generates the 6-bit ALU operator codes and the operand-select and control fields consumed by the team's ALU.
- Accepts one RV32I instruction word per handshake.
- Decodes it combinationally and presents the result from a single pipeline register with a valid/ready handshake toward execute.
- Flags illegal encodings rather than dropping them.
- Supports a flush from branch/jump resolution.

Parameters:
RESET_PC_SRC, 2'd0, reset value driven on src_a_sel_o.
ILLEGAL_CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n_i  in  1  asynchronous active-low reset
instr_i  in  32  instruction word
instr_valid_i  in  1  instr_i valid
instr_ready_o  out  1  stage can accept instr_i this cycle
flush_i  in  1  discard held and incoming instruction
out_valid_o  out  1  decoded fields valid
out_ready_i  in  1  execute accepts decoded fields
alu_op_o  out  6  ALU operator code
src_a_sel_o  out  2  0=rs1, 1=pc, 2=zero
src_b_sel_o  out  2  0=rs2, 1=imm, 2=const 4
imm_o  out  32  sign-extended immediate (I/S/B/U/J by format)
rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each  register indices
reg_we_o, branch_o, jal_o, jalr_o, mem_req_o, mem_we_o  out  1 each  control
mem_size_o  out  3  funct3 of load/store
illegal_instr_o  out  1  illegal encoding
illegal_cnt_o  out  ILLEGAL_CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Reset: clock clk_i; reset is asynchronous and active-low on rst_n_i. While rst_n_i=0:
  - out_valid_o=0, illegal_cnt_o=0, src_a_sel_o=RESET_PC_SRC.
  - All other registered outputs are 0.
  - Release is synchronous to the next rising edge.
- Handshake:
  - instr_ready_o = !out_valid_o || out_ready_i (combinational).
  - Accept when instr_valid_i && instr_ready_o && !flush_i. The decoded fields load on that edge and out_valid_o=1 on the next cycle. Latency is 1 cycle; throughput is 1 per cycle.
  - If out_ready_i=1 and no new accept, out_valid_o clears.
  - While out_valid_o && !out_ready_i, all outputs hold stable.
- Flush: flush_i=1 clears out_valid_o at the next edge and blocks any accept in the same cycle; flush has priority over load. illegal_cnt_o does not increment for a flushed word.
- ALU op mapping:
  - ADD=011000, SUB=011001, XOR=101111, OR=101110, AND=010101.
  - SRA=100100, SRL=100101, SLL=100111.
  - LTS=000000, LTU=000001, GES=001010, GEU=001011, EQ=001100, NE=001101.
- OP (0110011): the funct3/funct7 pair selects the op directly; SLT→LTS, SLTU→LTU. Only funct7 values 0000000 and 0100000 are legal, and 0100000 is legal only for SUB and SRA. src_b=rs2, reg_we=1.
- OP-IMM (0010011): same mapping with src_b=imm, except there is no SUBI. Shifts use imm[4:0] as shamt; for shifts, funct7 must be 0000000, or 0100000 for SRAI only.
- LUI: ADD, a=zero, b=imm. AUIPC: ADD, a=pc, b=imm.
- JAL: ADD, a=pc, b=4, jal=1, reg_we=1. JALR (funct3=000): same, jalr=1.
- BRANCH: BEQ→EQ, BNE→NE, BLT→LTS, BGE→GES, BLTU→LTU, BGEU→GEU. branch=1, reg_we=0, b=rs2. funct3 010/011 is illegal.
- LOAD: ADD, a=rs1, b=imm, mem_req=1, reg_we=1. Legal funct3: 000, 001, 010, 100, 101.
- STORE: ADD, mem_req=1, mem_we=1. Legal funct3: 000, 001, 010.
- MISC-MEM (FENCE): legal NOP, alu_op=ADD, no writes.
- Everything else is illegal, including instr_i[1:0]≠11 and SYSTEM.
- Illegal instruction:
  - Forwarded with illegal_instr_o=1, and reg_we, mem_req, mem_we, branch, jal, jalr forced to 0.
  - illegal_cnt_o increments by 1 per accepted illegal word and saturates at all-ones (no wrap).
- reg_we_o is forced to 0 when rd=0.
- Reset asserted mid-stall discards the held instruction.

Decomposition:
- Shared package rv32i_pkg holds:
  - the ALU operator code constants, identical to the ALU's values;
  - the opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, MISC_MEM, SYSTEM);
  - the src_a/src_b select encodings.
- One combinational sub-module, rv32i_decode_core (instr in → fields + illegal out), is natural.
- The top level holds the pipeline register, handshake, flush and counter.

Test Plan:
- ADD x3,x1,x2, instr_i=0x002081B3, valid, out_ready=1 → next cycle out_valid_o=1, alu_op_o=011000, rs1=1, rs2=2, rd=3, reg_we_o=1, src_b_sel_o=0.
- SRAI x1,x2,3, instr_i=0x40315093 → alu_op_o=100100, src_b_sel_o=1, imm_o[4:0]=3, rd=1, illegal=0.
- LUI x5,0x12345, instr_i=0x123452B7 → alu_op_o=011000, src_a_sel_o=2, imm_o=0x12345000, reg_we_o=1.
- instr_i=0xFFFFFFFF issued 3 times → illegal_instr_o=1, reg_we_o=0, mem_req_o=0, illegal_cnt_o=3. Preload near saturation: the count stays at all-ones.
- Stall: out_ready_i=0 for 4 cycles with a valid held instruction → instr_ready_o=0 and outputs stable. On release, back-to-back words stream at 1 per cycle.
- flush_i=1 with instr_valid_i=1 and a held instruction → next cycle out_valid_o=0, illegal_cnt_o unchanged. Async reset mid-stall → out_valid_o=0 immediately.
